// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings and instruction classes for the multi-cycle MIPS controller.
package multi_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    localparam logic [2:0] NPC_PC4 = 3'd0;
    localparam logic [2:0] NPC_BEQ = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;

    localparam logic [1:0] DM_WORD = 2'd0;
    localparam logic [1:0] DM_HALF = 2'd1;
    localparam logic [1:0] DM_BITE = 2'd2;

    localparam logic [1:0] M1_RT  = 2'd0;
    localparam logic [1:0] M1_RD  = 2'd1;
    localparam logic [1:0] M1_R31 = 2'd2;

    localparam logic [1:0] M2_ALU = 2'd0;
    localparam logic [1:0] M2_DW  = 2'd1;
    localparam logic [1:0] M2_NPC = 2'd2;
    localparam logic [1:0] M2_LUI = 2'd3;

    localparam logic M3_GRF = 1'b0;
    localparam logic M3_EXT = 1'b1;
    localparam logic M4_GRF = 1'b0;
    localparam logic M4_SA  = 1'b1;
    localparam logic EXT_ZERO   = 1'b0;
    localparam logic EXT_SIGNED = 1'b1;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [4:0] {
        I_NOP, I_ADDU, I_SUBU, I_ORI, I_LW, I_SW, I_BEQ, I_JAL, I_JR, I_SLT,
        I_LUI, I_LB, I_SB, I_LH, I_SH, I_SLL, I_SLLV, I_SLTU, I_J
    } instr_e;

    typedef struct packed {
        instr_e     instr;
        logic [3:0] alu_op;
        logic       ext_op;
        logic [1:0] dm_op;
        logic       if_signed;
        logic [1:0] m1_sel;
        logic [1:0] m2_sel;
        logic       m3_sel;
        logic       m4_sel;
    } dec_t;

    function automatic logic is_load(input instr_e i);
        return (i == I_LW) || (i == I_LH) || (i == I_LB);
    endfunction

    function automatic logic is_store(input instr_e i);
        return (i == I_SW) || (i == I_SH) || (i == I_SB);
    endfunction

    function automatic logic is_rtype(input instr_e i);
        return (i == I_ADDU) || (i == I_SUBU) || (i == I_SLT) || (i == I_SLTU) ||
               (i == I_SLL) || (i == I_SLLV) || (i == I_JR);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_decode.sv
// Combinational instruction decode: classifies Op/Func and produces the
// state-independent datapath selects.
module mc_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] func_i,
    output dec_t       dec_o
);

    instr_e instr;

    always_comb begin
        instr = I_NOP;
        case (op_i)
            OP_RTYPE: begin
                case (func_i)
                    FN_ADDU: instr = I_ADDU;
                    FN_SUBU: instr = I_SUBU;
                    FN_SLT:  instr = I_SLT;
                    FN_SLTU: instr = I_SLTU;
                    FN_SLL:  instr = I_SLL;
                    FN_SLLV: instr = I_SLLV;
                    FN_JR:   instr = I_JR;
                    default: instr = I_NOP;
                endcase
            end
            OP_ORI:  instr = I_ORI;
            OP_LUI:  instr = I_LUI;
            OP_LW:   instr = I_LW;
            OP_LH:   instr = I_LH;
            OP_LB:   instr = I_LB;
            OP_SW:   instr = I_SW;
            OP_SH:   instr = I_SH;
            OP_SB:   instr = I_SB;
            OP_BEQ:  instr = I_BEQ;
            OP_J:    instr = I_J;
            OP_JAL:  instr = I_JAL;
            default: instr = I_NOP;
        endcase
    end

    always_comb begin
        dec_o.instr     = instr;
        dec_o.alu_op    = ALU_ADD;
        dec_o.ext_op    = EXT_ZERO;
        dec_o.dm_op     = DM_WORD;
        dec_o.if_signed = 1'b0;
        dec_o.m1_sel    = M1_RT;
        dec_o.m2_sel    = M2_ALU;
        dec_o.m3_sel    = M3_GRF;
        dec_o.m4_sel    = M4_GRF;

        case (instr)
            I_SUBU, I_BEQ: dec_o.alu_op = ALU_SUB;
            I_ORI:         dec_o.alu_op = ALU_OR;
            I_SLT:         dec_o.alu_op = ALU_SLT;
            I_SLTU:        dec_o.alu_op = ALU_SLTU;
            I_SLL, I_SLLV: dec_o.alu_op = ALU_SLL;
            default:       dec_o.alu_op = ALU_ADD;
        endcase

        if (is_load(instr) || is_store(instr)) begin
            dec_o.ext_op = EXT_SIGNED;
            dec_o.m3_sel = M3_EXT;
        end
        if (instr == I_ORI)
            dec_o.m3_sel = M3_EXT;

        if ((instr == I_LH) || (instr == I_SH))
            dec_o.dm_op = DM_HALF;
        else if ((instr == I_LB) || (instr == I_SB))
            dec_o.dm_op = DM_BITE;

        dec_o.if_signed = (instr == I_LB) || (instr == I_LH);

        if (is_rtype(instr))
            dec_o.m1_sel = M1_RD;
        else if (instr == I_JAL)
            dec_o.m1_sel = M1_R31;

        if (is_load(instr))
            dec_o.m2_sel = M2_DW;
        else if (instr == I_LUI)
            dec_o.m2_sel = M2_LUI;
        else if (instr == I_JAL)
            dec_o.m2_sel = M2_NPC;

        if (instr == I_SLL)
            dec_o.m4_sel = M4_SA;
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and gates
// the architectural write enables.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Func,
    input  logic       Zero,
    input  logic       DMReady,
    output logic       PCWr,
    output logic       IRWr,
    output logic       WE,
    output logic       DMWr,
    output logic [2:0] NPCOp,
    output logic [3:0] ALUOp,
    output logic [1:0] DMOp,
    output logic [1:0] M1Sel,
    output logic [1:0] M2Sel,
    output logic       EXTOp,
    output logic       IfSigned,
    output logic       M3Sel,
    output logic       M4Sel,
    output logic [2:0] State,
    output logic       InstrDone
);

    dec_t   dec;
    state_e state_q, state_d;
    logic   done_q;
    logic   pc_wr, ir_wr, rf_we, dm_wr;
    logic [2:0] npc_op;

    mc_decode u_decode (
        .op_i   (Op),
        .func_i (Func),
        .dec_o  (dec)
    );

    // Enables are decoded from the current state because Op (fresh IR) and
    // Zero are only valid in the same cycle they are consumed.
    always_comb begin
        state_d = state_q;
        pc_wr   = 1'b0;
        ir_wr   = 1'b0;
        rf_we   = 1'b0;
        dm_wr   = 1'b0;
        npc_op  = NPC_PC4;
        case (state_q)
            ST_FETCH: begin
                ir_wr   = 1'b1;
                pc_wr   = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (dec.instr)
                    I_J: begin
                        pc_wr   = 1'b1;
                        npc_op  = NPC_J;
                        state_d = ST_FETCH;
                    end
                    I_JAL: begin
                        pc_wr   = 1'b1;
                        npc_op  = NPC_J;
                        rf_we   = 1'b1;
                        state_d = ST_FETCH;
                    end
                    I_JR: begin
                        pc_wr   = 1'b1;
                        npc_op  = NPC_JR;
                        state_d = ST_FETCH;
                    end
                    I_NOP:   state_d = ST_FETCH;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                if (dec.instr == I_BEQ) begin
                    npc_op  = NPC_BEQ;
                    pc_wr   = Zero;
                    state_d = ST_FETCH;
                end else if (is_load(dec.instr) || is_store(dec.instr)) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dm_wr = is_store(dec.instr);
                if (DMReady)
                    state_d = is_store(dec.instr) ? ST_FETCH : ST_WB;
            end
            ST_WB: begin
                rf_we   = 1'b1;
                state_d = ST_FETCH;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_FETCH;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == ST_FETCH) && (state_q != ST_FETCH);
        end
    end

    // Reset masks the enables combinationally so an in-flight access dies at once.
    assign PCWr      = reset & pc_wr;
    assign IRWr      = reset & ir_wr;
    assign WE        = reset & rf_we;
    assign DMWr      = reset & dm_wr;
    assign NPCOp     = npc_op;
    assign State     = state_q;
    assign InstrDone = done_q;

    assign ALUOp    = dec.alu_op;
    assign EXTOp    = dec.ext_op;
    assign DMOp     = dec.dm_op;
    assign IfSigned = dec.if_signed;
    assign M1Sel    = dec.m1_sel;
    assign M2Sel    = dec.m2_sel;
    assign M3Sel    = dec.m3_sel;
    assign M4Sel    = dec.m4_sel;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: directed cases plus random
// instruction streams compared against a per-instruction cycle model.
module tb_multi_cycle_ctrl;

    localparam int K_ALU = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_NOP = 4,
                   K_BEQ = 5, K_LOAD = 6, K_STORE = 7;
    localparam int NROWS = 21;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] Op = 6'h00, Func = 6'h00;
    logic       Zero = 1'b0, DMReady = 1'b0;
    logic       PCWr, IRWr, WE, DMWr, EXTOp, IfSigned, M3Sel, M4Sel, InstrDone;
    logic [2:0] NPCOp, State;
    logic [3:0] ALUOp;
    logic [1:0] DMOp, M1Sel, M2Sel;

    int n_checks = 0;
    int n_errors = 0;

    string      nm  [NROWS];
    logic [5:0] opv [NROWS];
    logic [5:0] fnv [NROWS];

    multi_cycle_ctrl dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .Zero(Zero), .DMReady(DMReady),
        .PCWr(PCWr), .IRWr(IRWr), .WE(WE), .DMWr(DMWr), .NPCOp(NPCOp), .ALUOp(ALUOp),
        .DMOp(DMOp), .M1Sel(M1Sel), .M2Sel(M2Sel), .EXTOp(EXTOp), .IfSigned(IfSigned),
        .M3Sel(M3Sel), .M4Sel(M4Sel), .State(State), .InstrDone(InstrDone)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic set_row(input int i, input string n, input logic [5:0] o, input logic [5:0] f);
        nm[i] = n; opv[i] = o; fnv[i] = f;
    endtask

    function automatic bit in_set(input string n, input string s0, input string s1 = "",
                                  input string s2 = "", input string s3 = "");
        return (n == s0) || (n == s1 && s1 != "") || (n == s2 && s2 != "") || (n == s3 && s3 != "");
    endfunction

    function automatic int kind_of(input string n);
        if (n == "j")   return K_J;
        if (n == "jal") return K_JAL;
        if (n == "jr")  return K_JR;
        if (n == "beq") return K_BEQ;
        if (in_set(n, "lw", "lh", "lb")) return K_LOAD;
        if (in_set(n, "sw", "sh", "sb")) return K_STORE;
        if (n.len() >= 3 && n.substr(0, 2) == "nop") return K_NOP;
        return K_ALU;
    endfunction

    // {ALUOp, EXTOp, DMOp, IfSigned, M1Sel, M2Sel, M3Sel, M4Sel}
    function automatic logic [14:0] exp_dec(input string n);
        logic [3:0] alu; logic ext, ifs, m3, m4; logic [1:0] dm, m1, m2;
        int k;
        k   = kind_of(n);
        alu = 4'd0;
        if (in_set(n, "subu", "beq")) alu = 4'd1;
        if (n == "ori")  alu = 4'd2;
        if (n == "slt")  alu = 4'd3;
        if (n == "sltu") alu = 4'd4;
        if (in_set(n, "sll", "sllv")) alu = 4'd5;
        ext = (k == K_LOAD || k == K_STORE);
        dm  = in_set(n, "lh", "sh") ? 2'd1 : in_set(n, "lb", "sb") ? 2'd2 : 2'd0;
        ifs = in_set(n, "lb", "lh");
        m1  = (in_set(n, "addu", "subu", "slt", "sltu") || in_set(n, "sll", "sllv", "jr")) ? 2'd1 :
              (n == "jal") ? 2'd2 : 2'd0;
        m2  = (k == K_LOAD) ? 2'd1 : (n == "lui") ? 2'd3 : (n == "jal") ? 2'd2 : 2'd0;
        m3  = ext || (n == "ori");
        m4  = (n == "sll");
        return {alu, ext, dm, ifs, m1, m2, m3, m4};
    endfunction

    // {State, PCWr, IRWr, WE, DMWr, NPCOp, InstrDone}
    function automatic logic [10:0] exp_ctl(input int st, input int k, input bit z, input bit done);
        logic pc, ir, we, dm; logic [2:0] npc;
        pc = 0; ir = 0; we = 0; dm = 0; npc = 3'd0;
        case (st)
            0: begin pc = 1; ir = 1; end
            1: begin
                if (k == K_J || k == K_JAL) begin pc = 1; npc = 3'd2; end
                if (k == K_JAL) we = 1;
                if (k == K_JR) begin pc = 1; npc = 3'd3; end
            end
            2: if (k == K_BEQ) begin pc = z; npc = 3'd1; end
            3: dm = (k == K_STORE);
            4: we = 1;
            default: ;
        endcase
        return {3'(st), pc, ir, we, dm, npc, done};
    endfunction

    function automatic logic [10:0] obs_ctl();
        return {State, PCWr, IRWr, WE, DMWr, NPCOp, InstrDone};
    endfunction

    function automatic logic [14:0] obs_dec();
        return {ALUOp, EXTOp, DMOp, IfSigned, M1Sel, M2Sel, M3Sel, M4Sel};
    endfunction

    // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 in the next FETCH.
    task automatic run_instr(input int idx, input bit z, input int w, input bit after_reset);
        int sq[$];
        int k, mcnt;
        k  = kind_of(nm[idx]);
        Op = opv[idx];
        Func = (opv[idx] == 6'h00) ? fnv[idx] : 6'($urandom);
        Zero = z;
        sq = {0, 1};
        if (!(k inside {K_J, K_JAL, K_JR, K_NOP})) begin
            sq.push_back(2);
            if (k == K_LOAD || k == K_STORE)
                for (int m = 0; m <= w; m++) sq.push_back(3);
            if (k != K_BEQ && k != K_STORE) sq.push_back(4);
        end
        mcnt = 0;
        for (int c = 0; c < sq.size(); c++) begin
            if (sq[c] == 3) begin
                DMReady = (mcnt >= w);
                mcnt++;
            end else begin
                DMReady = 1'($urandom);
            end
            @(negedge clk);
            if (c == 0) check({"dec_", nm[idx]}, 32'(obs_dec()), 32'(exp_dec(nm[idx])));
            check({"ctl_", nm[idx]}, 32'(obs_ctl()), 32'(exp_ctl(sq[c], k, z, (c == 0) && !after_reset)));
            @(posedge clk); #1;
        end
    endtask

    function automatic int find_row(input string n);
        for (int i = 0; i < NROWS; i++) if (nm[i] == n) return i;
        return 0;
    endfunction

    initial begin
        set_row(0, "addu", 6'h00, 6'h21);  set_row(1, "subu", 6'h00, 6'h23);
        set_row(2, "slt",  6'h00, 6'h2A);  set_row(3, "sltu", 6'h00, 6'h2B);
        set_row(4, "sll",  6'h00, 6'h00);  set_row(5, "sllv", 6'h00, 6'h04);
        set_row(6, "jr",   6'h00, 6'h08);  set_row(7, "ori",  6'h0D, 6'h00);
        set_row(8, "lw",   6'h23, 6'h00);  set_row(9, "sw",   6'h2B, 6'h00);
        set_row(10, "beq", 6'h04, 6'h00);  set_row(11, "jal", 6'h03, 6'h00);
        set_row(12, "j",   6'h02, 6'h00);  set_row(13, "lui", 6'h0F, 6'h00);
        set_row(14, "lb",  6'h20, 6'h00);  set_row(15, "sb",  6'h28, 6'h00);
        set_row(16, "lh",  6'h21, 6'h00);  set_row(17, "sh",  6'h29, 6'h00);
        set_row(18, "nop_3f", 6'h3F, 6'h00);
        set_row(19, "nop_add", 6'h00, 6'h20);
        set_row(20, "nop_addi", 6'h08, 6'h00);

        // Reset: FETCH state but every enable masked.
        reset = 1'b0; Op = 6'h23; DMReady = 1'b1;
        @(posedge clk); #1;
        check("reset_state", 32'(obs_ctl()), 32'(exp_ctl(0, K_NOP, 0, 0) & 11'b111_0000_000_1));
        reset = 1'b1;

        run_instr(find_row("addu"), 0, 0, 1);
        run_instr(find_row("lw"), 0, 2, 0);
        run_instr(find_row("beq"), 0, 0, 0);
        run_instr(find_row("beq"), 1, 0, 0);
        run_instr(find_row("jal"), 0, 0, 0);
        run_instr(find_row("nop_3f"), 0, 0, 0);
        run_instr(find_row("sw"), 0, 0, 0);
        run_instr(find_row("lh"), 0, 0, 0);

        // sw aborted by reset during a MEM wait.
        Op = 6'h2B; Func = 6'h00; Zero = 1'b0; DMReady = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("abort_pre", 32'(obs_ctl()), 32'(exp_ctl(c < 3 ? c : 3, K_STORE, 0, c == 0)));
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1 check("abort_now", 32'(obs_ctl()), 32'(11'b000_0000_000_0));
        @(posedge clk); #1;
        check("abort_hold", 32'(obs_ctl()), 32'(11'b000_0000_000_0));
        reset = 1'b1;
        run_instr(find_row("addu"), 0, 0, 1);

        for (int n = 0; n < 120; n++)
            run_instr(int'($urandom_range(NROWS - 1)), 1'($urandom), int'($urandom_range(3)), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
